// File: rtl/id_operand_fetch_pkg.sv
// Shared constants, types and small helpers for the decode-stage operand block.
package id_operand_fetch_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_CNT   = 16;
  localparam int REG_IDX_W = 4;

  // R15 is the PC: reads return PC+4 of the decoding instruction, writes are dropped.
  localparam logic [REG_IDX_W-1:0] REG_PC = 4'd15;

  // NZCV bit positions inside the 4-bit status register.
  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // True when a source operand that is actually read depends on a pending
  // destination. R15 is never a writable destination, so it never matches.
  function automatic logic dep_hit(
    input logic                 used,
    input logic                 dest_we,
    input logic [REG_IDX_W-1:0] dest,
    input logic [REG_IDX_W-1:0] src
  );
    return used & dest_we & (dest == src) & (src != REG_PC);
  endfunction

endpackage

// File: rtl/id_operand_fetch_register_file.sv
// 16-entry architectural register file with a write-through bypass on both
// read ports and PC substitution for reads of R15.
module id_operand_fetch_register_file #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [3:0]        rd_idx_a,
  input  logic [3:0]        rd_idx_b,
  input  logic              wr_en,
  input  logic [3:0]        wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);
  import id_operand_fetch_pkg::*;

  logic [DATA_W-1:0] mem_q [REG_CNT];
  logic [DATA_W-1:0] mem_d [REG_CNT];
  logic              wr_ok;

  // Writes to R15 are suppressed; the real PC lives in the fetch stage.
  assign wr_ok = wr_en && (wr_idx != REG_PC);

  // Next-state of the storage array: only the addressed entry changes.
  always_comb begin
    for (int i = 0; i < REG_CNT; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_ok) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  // Storage registers; reset clears every entry and wins over a same-edge write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_CNT; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Port A read: PC for R15, write-back data on a same-cycle hit, else storage.
  always_comb begin
    rd_data_a = mem_q[rd_idx_a];
    if (rd_idx_a == REG_PC) begin
      rd_data_a = pc_in;
    end else if (wr_ok && (wr_idx == rd_idx_a)) begin
      rd_data_a = wr_data;
    end
  end

  // Port B read: identical function of its own index.
  always_comb begin
    rd_data_b = mem_q[rd_idx_b];
    if (rd_idx_b == REG_PC) begin
      rd_data_b = pc_in;
    end else if (wr_ok && (wr_idx == rd_idx_b)) begin
      rd_data_b = wr_data;
    end
  end

endmodule

// File: rtl/id_operand_fetch.sv
// Decode-stage operand fetch: register file reads with WB bypass, NZCV status
// register, and the read-after-write stall request for the front of the pipe.
module id_operand_fetch #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [3:0]        src1,
  input  logic [3:0]        src2,
  input  logic              src1_used,
  input  logic              two_src,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              exe_wb_en,
  input  logic [3:0]        exe_dest,
  input  logic              exe_mem_r_en,
  input  logic              mem_wb_en,
  input  logic [3:0]        mem_dest,
  input  logic              forward_en,
  input  logic              sr_we,
  input  logic [3:0]        sr_in,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic [3:0]        sr_out,
  output logic              hazard
);
  import id_operand_fetch_pkg::*;

  nzcv_t sr_q;
  nzcv_t sr_d;

  logic rn_exe_dep;
  logic rn_mem_dep;
  logic rm_exe_dep;
  logic rm_mem_dep;

  id_operand_fetch_register_file #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_register_file (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .rd_idx_a  (src1),
    .rd_idx_b  (src2),
    .wr_en     (wb_en),
    .wr_idx    (wb_dest),
    .wr_data   (wb_value),
    .rd_data_a (val_rn),
    .rd_data_b (val_rm)
  );

  // Status register next-state: load ALU flags when EXE commits an S-bit op.
  always_comb begin
    sr_d = sr_q;
    if (sr_we) begin
      sr_d.n = sr_in[SR_N];
      sr_d.z = sr_in[SR_Z];
      sr_d.c = sr_in[SR_C];
      sr_d.v = sr_in[SR_V];
    end
  end

  // Status register flop; reset clears flags and wins over a same-edge update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr_out = sr_q;

  // Hazard detection: any pending producer without forwarding, load-use only with it.
  always_comb begin
    rn_exe_dep = dep_hit(src1_used, exe_wb_en, exe_dest, src1);
    rn_mem_dep = dep_hit(src1_used, mem_wb_en, mem_dest, src1);
    rm_exe_dep = dep_hit(two_src,   exe_wb_en, exe_dest, src2);
    rm_mem_dep = dep_hit(two_src,   mem_wb_en, mem_dest, src2);
    hazard     = 1'b0;
    if (forward_en) begin
      // EXE and MEM results are forwarded; only a load in EXE is too late.
      hazard = exe_mem_r_en & (rn_exe_dep | rm_exe_dep);
    end else begin
      hazard = rn_exe_dep | rn_mem_dep | rm_exe_dep | rm_mem_dep;
    end
  end

endmodule
